llc_lookup_ctrl: RTL
====================

Name: llc_lookup_ctrl

Overview:
Sequencing controller for the 4-way, 1 KB, 64 B-line last-level cache model. Accepts one request at a time and holds tag, valid and dirty state plus 3-bit tree pseudo-LRU per set. Performs lookup, victim selection, dirty-victim writeback and line fill over valid/ready handshakes to a memory model, then returns HIT/MISS. Sits between the trace-driven request source and the memory model; keeps hit and miss counters for the simulator report.

Parameters:
ADDR_SIZE, 32, request/memory address width (from cache_define)
ASSOC, 4, ways per set; the PLRU encoding below is fixed for 4
INDEX, 4, number of sets; INDEX_BITS=2, BYTE_BITS=6, TAG_BITS=24, LRU_BITS=3 (derived in cache_define)
CNT_W, 32, width of the statistics counters

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  controller can accept a request
req_addr  in  ADDR_SIZE  byte address
req_we  in  1  1=write, 0=read
rsp_valid  out  1  result available
rsp_ready  in  1  consumer takes result
rsp_result  out  2  HIT=1, MISS=2 (cache_define codes)
rsp_way  out  2  way hit or filled
rsp_evict  out  1  a dirty victim was written back
mem_wb_valid  out  1  writeback request
mem_wb_ready  in  1  memory accepts writeback
mem_wb_addr  out  ADDR_SIZE  victim line address {tag,index,6'b0}
mem_rd_valid  out  1  fill request
mem_rd_ready  in  1  memory accepts fill / data returned
mem_rd_addr  out  ADDR_SIZE  line address {tag,index,6'b0}
hit_count  out  CNT_W  completed hits
miss_count  out  CNT_W  completed misses

Behaviour:
- Address split: tag=addr[31:8], index=addr[7:6], offset=addr[5:0] (offset ignored).
- FSM states: IDLE, LOOKUP, WB, FILL, RESP. req_ready=1 only in IDLE; accept on req_valid&&req_ready and latch addr and we.
- LOOKUP (1 cycle): compare tag against the 4 ways of the set, valid-qualified. Hit -> update PLRU; set dirty if we; go to RESP, result HIT. Miss -> pick victim: lowest-index invalid way, otherwise PLRU way. Victim valid&&dirty -> WB, else FILL.
- WB: mem_wb_valid=1 with addr stable until mem_wb_ready; on the handshake cycle go to FILL.
- FILL: mem_rd_valid=1 with addr stable until mem_rd_ready. On handshake: write tag, valid=1, dirty=we; update PLRU; go to RESP with result MISS.
- RESP: rsp_valid held with result, way and evict stable until rsp_ready; then IDLE. The counter increments on the rsp handshake.
- Hit latency: accepted cycle N, rsp_valid at N+2. A clean miss with mem_rd_ready already high gives rsp_valid at N+3.
- PLRU bits b[2:0]; victim: b0=0 -> {0,1}: b1 ? way1 : way0; b0=1 -> {2,3}: b2 ? way3 : way2.
- PLRU update on access: way0 -> b0=1,b1=1; way1 -> b0=1,b1=0; way2 -> b0=0,b2=1; way3 -> b0=0,b2=0. Unaffected bit is held.
- Counters wrap modulo 2^CNT_W.
- Reset (any state, including mid-WB/FILL): state=IDLE; all valid, dirty and PLRU bits cleared; counters=0. After reset: req_ready=1, every other output 0. Any in-flight memory handshake is abandoned.
- No request is accepted while busy; req_valid may stay high indefinitely.

Decomposition:
- cache_define package adds: state enum typedef, a tag/valid/dirty line struct typedef, and the address field-slice functions.
- One sub-module, llc_plru4: combinational victim select plus next-state PLRU bits from (b, accessed way). The per-set PLRU registers stay in the controller.

Test Plan:
- After reset, read 0x0000_0000 -> MISS, way0, mem_rd_addr 0x0000_0000, no WB, miss_count=1. Repeat read -> HIT, way0, rsp_valid 2 cycles after accept, hit_count=1.
- Reads 0x000, 0x100, 0x200, 0x300 (all set 0) -> MISS, ways 0,1,2,3. Then read 0x400 -> MISS, victim way0 (PLRU b=000), no WB.
- Write 0x000 on an empty cache, fill set 0 as above, then read 0x400 -> mem_wb_addr 0x0000_0000 precedes mem_rd_addr 0x0000_0400; rsp_evict=1.
- Hold mem_rd_ready=0 for 5 cycles during FILL -> mem_rd_valid and mem_rd_addr stable, req_ready=0. Hold rsp_ready=0 for 3 cycles -> rsp fields stable.
- Assert rst during FILL -> all outputs return to reset values immediately; a following read of the same address -> MISS, counters restart from 0.

Source files
------------

// File: rtl/llc_lookup_ctrl_pkg.sv
// Shared types, geometry constants and address helpers for the
// last-level cache lookup controller (4-way, 4 sets, 64 B lines).
package llc_lookup_ctrl_pkg;

  localparam int ADDR_SIZE  = 32;
  localparam int ASSOC      = 4;
  localparam int INDEX      = 4;
  localparam int INDEX_BITS = 2;
  localparam int BYTE_BITS  = 6;
  localparam int TAG_BITS   = 24;
  localparam int LRU_BITS   = 3;
  localparam int WAY_BITS   = 2;
  localparam int CNT_W      = 32;

  localparam logic [1:0] RESULT_HIT  = 2'd1;
  localparam logic [1:0] RESULT_MISS = 2'd2;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WB,
    FILL,
    RESP
  } ctrlState_e;

  typedef struct packed {
    logic [TAG_BITS-1:0] tag;
    logic                valid;
    logic                dirty;
  } lineState_t;

  function automatic logic [TAG_BITS-1:0] addrTag(input logic [ADDR_SIZE-1:0] addr);
    return addr[ADDR_SIZE-1 -: TAG_BITS];
  endfunction

  function automatic logic [INDEX_BITS-1:0] addrIndex(input logic [ADDR_SIZE-1:0] addr);
    return addr[BYTE_BITS +: INDEX_BITS];
  endfunction

  function automatic logic [ADDR_SIZE-1:0] lineAddr(input logic [TAG_BITS-1:0]   tag,
                                                    input logic [INDEX_BITS-1:0] index);
    return {tag, index, {BYTE_BITS{1'b0}}};
  endfunction

endpackage

// File: rtl/llc_lookup_ctrl_if.sv
// Request, response and memory-side handshake bundle of the cache controller.
// The slave view is the controller itself; the master view is its environment
// (request source, result consumer and memory model).
interface llc_lookup_ctrl_if;
  import llc_lookup_ctrl_pkg::*;

  logic                 req_valid;
  logic                 req_ready;
  logic [ADDR_SIZE-1:0] req_addr;
  logic                 req_we;

  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [1:0]           rsp_result;
  logic [WAY_BITS-1:0]  rsp_way;
  logic                 rsp_evict;

  logic                 mem_wb_valid;
  logic                 mem_wb_ready;
  logic [ADDR_SIZE-1:0] mem_wb_addr;
  logic                 mem_rd_valid;
  logic                 mem_rd_ready;
  logic [ADDR_SIZE-1:0] mem_rd_addr;

  logic [CNT_W-1:0]     hit_count;
  logic [CNT_W-1:0]     miss_count;

  modport slave (
    input  req_valid, req_addr, req_we, rsp_ready, mem_wb_ready, mem_rd_ready,
    output req_ready, rsp_valid, rsp_result, rsp_way, rsp_evict,
           mem_wb_valid, mem_wb_addr, mem_rd_valid, mem_rd_addr,
           hit_count, miss_count
  );

  modport master (
    output req_valid, req_addr, req_we, rsp_ready, mem_wb_ready, mem_rd_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_way, rsp_evict,
           mem_wb_valid, mem_wb_addr, mem_rd_valid, mem_rd_addr,
           hit_count, miss_count
  );

endinterface

// File: rtl/llc_lookup_ctrl_plru4.sv
// Tree pseudo-LRU for one 4-way set: picks the victim from the current bits
// and computes the bits after an access. Bit 0 chooses the way pair, bit 1
// chooses within ways {0,1}, bit 2 within ways {2,3}.
module llc_plru4
  import llc_lookup_ctrl_pkg::*;
(
  input  logic [LRU_BITS-1:0] plruBits_i,
  input  logic [WAY_BITS-1:0] accessWay_i,
  output logic [WAY_BITS-1:0] victimWay_o,
  output logic [LRU_BITS-1:0] plruNext_o
);

  // Follow the tree bits down to the least recently used way.
  always_comb begin
    victimWay_o = 2'd0;
    if (!plruBits_i[0]) begin
      victimWay_o = plruBits_i[1] ? 2'd1 : 2'd0;
    end else begin
      victimWay_o = plruBits_i[2] ? 2'd3 : 2'd2;
    end
  end

  // Point the tree away from the accessed way; the other pair's bit is untouched.
  always_comb begin
    plruNext_o = plruBits_i;
    case (accessWay_i)
      2'd0: begin plruNext_o[0] = 1'b1; plruNext_o[1] = 1'b1; end
      2'd1: begin plruNext_o[0] = 1'b1; plruNext_o[1] = 1'b0; end
      2'd2: begin plruNext_o[0] = 1'b0; plruNext_o[2] = 1'b1; end
      2'd3: begin plruNext_o[0] = 1'b0; plruNext_o[2] = 1'b0; end
    endcase
  end

endmodule

// File: rtl/llc_lookup_ctrl.sv
// Cache lookup sequencer: accepts one request, looks it up in the tag store,
// writes back a dirty victim and fills the line on a miss, then reports
// HIT/MISS and keeps running hit/miss totals.
module llc_lookup_ctrl
  import llc_lookup_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  llc_lookup_ctrl_if.slave bus
);

  ctrlState_e           state_q, state_d;
  logic [TAG_BITS-1:0]  reqTag_q;
  logic [INDEX_BITS-1:0] reqIndex_q;
  logic                 reqWe_q;
  lineState_t           lines_q [INDEX][ASSOC];
  logic [LRU_BITS-1:0]  plru_q [INDEX];
  logic [WAY_BITS-1:0]  way_q;
  logic [1:0]           result_q;
  logic                 evict_q;
  logic [ADDR_SIZE-1:0] wbAddr_q;
  logic [CNT_W-1:0]     hitCount_q;
  logic [CNT_W-1:0]     missCount_q;

  logic                 lookupHit;
  logic [WAY_BITS-1:0]  hitWay;
  logic                 invalidFound;
  logic [WAY_BITS-1:0]  invalidWay;
  logic [WAY_BITS-1:0]  missWay;
  logic                 victimDirty;
  logic [WAY_BITS-1:0]  plruVictim;
  logic [WAY_BITS-1:0]  plruAccessWay;
  logic [LRU_BITS-1:0]  plruNext;

  // A hit touches the hit way during LOOKUP; a fill touches the chosen victim.
  assign plruAccessWay = (state_q == LOOKUP) ? hitWay : way_q;

  llc_plru4 uPlru (
    .plruBits_i  (plru_q[reqIndex_q]),
    .accessWay_i (plruAccessWay),
    .victimWay_o (plruVictim),
    .plruNext_o  (plruNext)
  );

  // Tag compare across the set plus victim choice: an empty way beats PLRU.
  always_comb begin
    lookupHit    = 1'b0;
    hitWay       = '0;
    invalidFound = 1'b0;
    invalidWay   = '0;
    for (int w = 0; w < ASSOC; w++) begin
      if (lines_q[reqIndex_q][w].valid && (lines_q[reqIndex_q][w].tag == reqTag_q)) begin
        lookupHit = 1'b1;
        hitWay    = WAY_BITS'(w);
      end
    end
    for (int w = ASSOC - 1; w >= 0; w--) begin
      if (!lines_q[reqIndex_q][w].valid) begin
        invalidFound = 1'b1;
        invalidWay   = WAY_BITS'(w);
      end
    end
    missWay     = invalidFound ? invalidWay : plruVictim;
    victimDirty = lines_q[reqIndex_q][missWay].valid && lines_q[reqIndex_q][missWay].dirty;
  end

  // Control state register; reset drops any in-flight memory handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state sequencing driven by the handshake on each phase.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.req_valid) state_d = LOOKUP;
      LOOKUP: begin
        if (lookupHit)        state_d = RESP;
        else if (victimDirty) state_d = WB;
        else                  state_d = FILL;
      end
      WB:      if (bus.mem_wb_ready) state_d = FILL;
      FILL:    if (bus.mem_rd_ready) state_d = RESP;
      RESP:    if (bus.rsp_ready)    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request latch, tag store, PLRU, response fields and statistics.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reqTag_q    <= '0;
      reqIndex_q  <= '0;
      reqWe_q     <= 1'b0;
      way_q       <= '0;
      result_q    <= '0;
      evict_q     <= 1'b0;
      wbAddr_q    <= '0;
      hitCount_q  <= '0;
      missCount_q <= '0;
      for (int s = 0; s < INDEX; s++) begin
        plru_q[s] <= '0;
        for (int w = 0; w < ASSOC; w++) begin
          lines_q[s][w] <= '0;
        end
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            reqTag_q   <= addrTag(bus.req_addr);
            reqIndex_q <= addrIndex(bus.req_addr);
            reqWe_q    <= bus.req_we;
          end
        end
        LOOKUP: begin
          if (lookupHit) begin
            way_q              <= hitWay;
            result_q           <= RESULT_HIT;
            evict_q            <= 1'b0;
            plru_q[reqIndex_q] <= plruNext;
            if (reqWe_q) begin
              lines_q[reqIndex_q][hitWay].dirty <= 1'b1;
            end
          end else begin
            way_q    <= missWay;
            result_q <= RESULT_MISS;
            evict_q  <= victimDirty;
            wbAddr_q <= lineAddr(lines_q[reqIndex_q][missWay].tag, reqIndex_q);
          end
        end
        FILL: begin
          if (bus.mem_rd_ready) begin
            lines_q[reqIndex_q][way_q] <= '{tag: reqTag_q, valid: 1'b1, dirty: reqWe_q};
            plru_q[reqIndex_q]         <= plruNext;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            if (result_q == RESULT_HIT) hitCount_q  <= hitCount_q + CNT_W'(1);
            else                        missCount_q <= missCount_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready    = (state_q == IDLE);
  assign bus.rsp_valid    = (state_q == RESP);
  assign bus.rsp_result   = result_q;
  assign bus.rsp_way      = way_q;
  assign bus.rsp_evict    = evict_q;
  assign bus.mem_wb_valid = (state_q == WB);
  assign bus.mem_wb_addr  = wbAddr_q;
  assign bus.mem_rd_valid = (state_q == FILL);
  assign bus.mem_rd_addr  = lineAddr(reqTag_q, reqIndex_q);
  assign bus.hit_count    = hitCount_q;
  assign bus.miss_count   = missCount_q;

endmodule
